// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding and constants for the PC/fetch sequencer.
package pc_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, HALT, TRAP} pc_state_e;
  localparam int PC_INC = 4;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC and link-value computation.
module pc_next_calc import pc_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_jump_cntr,
  input  logic            i_is_jalr,
  output logic [XLEN-1:0] o_next_pc,
  output logic [XLEN-1:0] o_pc_plus4
);
  logic [XLEN-1:0] jalr_sum;
  always_comb begin
    o_pc_plus4 = i_pc + XLEN'(PC_INC);
    jalr_sum = i_rs1 + i_imm;
    o_next_pc = !i_jump_cntr ? o_pc_plus4 :
                i_is_jalr    ? {jalr_sum[XLEN-1:1], 1'b0} : i_pc + i_imm;
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and fetch/execute sequencer with req/ack imem handshake.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of masking them.
module pc_fetch_ctrl import pc_pkg::*; #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEFAULT_RESET_ADDR)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  output logic            o_instr_valid,
  input  logic            i_stall,
  input  logic            i_jump_cntr,
  input  logic            i_is_jalr,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_halt,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_halted
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            o_trap
`endif
);
  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, next_pc;
  logic            req_q, req_d;
  pc_next_calc #(.XLEN(XLEN)) u_calc (
    .i_pc        (pc_q),
    .i_imm       (i_imm),
    .i_rs1       (i_rs1),
    .i_jump_cntr (i_jump_cntr),
    .i_is_jalr   (i_is_jalr),
    .o_next_pc   (next_pc),
    .o_pc_plus4  (o_pc_plus4)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_d = 1'b0;
    case (state_q)
      FETCH: begin
        // an ack only counts once the registered request is visible to memory
        req_d = !(req_q && i_imem_ack);
        state_d = (req_q && i_imem_ack) ? EXEC : FETCH;
      end
      EXEC: if (!i_stall) begin
        if (i_halt) state_d = HALT;
`ifdef PC_MISALIGN_TRAP_EN
        else if (next_pc[1:0] != 2'b00) state_d = TRAP;
`endif
        else begin
          state_d = FETCH;
          req_d = 1'b1;
          pc_d = next_pc & ~XLEN'(2'b11);
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= FETCH;
      pc_q <= RESET_ADDR;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_q <= req_d;
    end
  assign o_imem_req = req_q;
  assign o_imem_addr = pc_q;
  assign o_pc = pc_q;
  assign o_instr_valid = state_q == EXEC;
  assign o_halted = state_q == HALT || state_q == TRAP;
`ifdef PC_MISALIGN_TRAP_EN
  assign o_trap = state_q == TRAP;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench with a behavioural fetch/retire model checked every cycle.
module tb_pc_fetch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ack = 1'b0, stall = 1'b0, jump = 1'b0, jalr = 1'b0, halt = 1'b0;
  logic [31:0] imm = '0, rs1 = '0;
  logic req, valid, halted;
  logic [31:0] addr, pc, pc4;
  logic trap;
  int vectors = 0, miscompares = 0;
  logic [31:0] m_pc = '0;
  logic m_req = 1'b0, m_valid = 1'b0, m_halt = 1'b0, m_trap = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .o_instr_valid(valid), .i_stall(stall), .i_jump_cntr(jump),
    .i_is_jalr(jalr), .i_imm(imm), .i_rs1(rs1), .i_halt(halt), .o_pc(pc),
    .o_pc_plus4(pc4), .o_halted(halted)
`ifdef PC_MISALIGN_TRAP_EN
    , .o_trap(trap)
`endif
  );
`ifndef PC_MISALIGN_TRAP_EN
  assign trap = 1'b0;
`endif

  function automatic logic [31:0] target(logic [31:0] p, logic j, logic r, logic [31:0] im, logic [31:0] s);
    if (!j) return p + 32'd4;
    if (r) return (s + im) & 32'hFFFF_FFFE;
    return p + im;
  endfunction

  // model: one instruction is either being fetched or executed until a halt/trap sticks
  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] t;
    if (!rst_n) begin
      m_pc <= 32'h0; m_req <= 1'b0; m_valid <= 1'b0; m_halt <= 1'b0; m_trap <= 1'b0;
    end else if (!m_halt) begin
      if (!m_valid) begin
        if (m_req && ack) begin m_req <= 1'b0; m_valid <= 1'b1; end
        else m_req <= 1'b1;
      end else if (!stall) begin
        t = target(m_pc, jump, jalr, imm, rs1);
        m_valid <= 1'b0;
        if (halt) m_halt <= 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        else if (t[1:0] != 2'b00) begin m_halt <= 1'b1; m_trap <= 1'b1; end
`endif
        else begin m_pc <= {t[31:2], 2'b00}; m_req <= 1'b1; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("imem_addr", addr, m_pc);
    chk("pc_plus4", pc4, m_pc + 32'd4);
    chk("imem_req", {31'd0, req}, {31'd0, m_req});
    chk("instr_valid", {31'd0, valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("trap", {31'd0, trap}, {31'd0, m_trap});
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic fetch_ack(input int dly);
    for (int i = 0; i < 20 && !req; i++) cyc();
    chk("req_seen", {31'd0, req}, 32'd1);
    repeat (dly) cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  task automatic retire(input logic j, input logic r, input logic [31:0] im, input logic [31:0] s, input logic h);
    stall = 1'b0; jump = j; jalr = r; imm = im; rs1 = s; halt = h;
    cyc();
    jump = 1'b0; jalr = 1'b0; imm = '0; rs1 = '0; halt = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, req}, 32'd0);
    #9 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_ack(i % 2);
      chk("seq_pc", pc, 32'(4 * i));
      chk("seq_valid", {31'd0, valid}, 32'd1);
      retire(1'b0, 1'b0, '0, '0, 1'b0);
    end
    fetch_ack(1);
    retire(1'b1, 1'b0, 32'h30, '0, 1'b0);
    fetch_ack(0);
    chk("at_40", pc, 32'h40);
    retire(1'b1, 1'b0, 32'hFFFF_FFF8, '0, 1'b0);
    chk("branch_addr", addr, 32'h38);
    chk("branch_req", {31'd0, req}, 32'd1);
    fetch_ack(2);
    retire(1'b1, 1'b1, 32'h4, 32'h101, 1'b0);
    chk("jalr_addr", addr, 32'h104);
    fetch_ack(0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      jump = k[0]; imm = 32'h77;
      cyc();
      chk("stall_pc", pc, 32'h104);
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_req", {31'd0, req}, 32'd0);
    end
    retire(1'b1, 1'b1, 32'h4, 32'h1C, 1'b0);
    chk("release_pc", pc, 32'h20);
    fetch_ack(0);
    retire(1'b1, 1'b0, 32'h100, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ack = k[0];
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, 32'h20);
      chk("halt_req", {31'd0, req}, 32'd0);
      cyc();
    end
    ack = 1'b0;
    rst_n = 1'b0;
    #1 chk("rst2_pc", pc, 32'h0);
    cyc();
    rst_n = 1'b1;
    fetch_ack(0);
    retire(1'b0, 1'b0, '0, '0, 1'b0);
    chk("pre_rst_pc", pc, 32'h4);
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk("midwait_pc", pc, 32'h0);
    chk("midwait_req", {31'd0, req}, 32'd0);
    ack = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    ack = 1'b0;
    chk("fresh_req", {31'd0, req}, 32'd1);
    chk("late_ack_valid", {31'd0, valid}, 32'd0);
    fetch_ack(5);
    chk("delayed_pc", pc, 32'h0);
    chk("delayed_valid", {31'd0, valid}, 32'd1);
    retire(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0);
    fetch_ack(0);
    chk("wrap_plus4", pc4, 32'h0);
    retire(1'b0, 1'b0, '0, '0, 1'b0);
    chk("wrap_pc", pc, 32'h0);
    fetch_ack(0);
    retire(1'b1, 1'b0, 32'h6, '0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign_trap", {31'd0, trap}, 32'd1);
    chk("misalign_halted", {31'd0, halted}, 32'd1);
    chk("misalign_pc", pc, 32'h0);
`else
    chk("misalign_addr", addr, 32'h4);
    chk("misalign_req", {31'd0, req}, 32'd1);
`endif
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
